// File: rtl/qam_rx_symbol_sampler_pkg.sv
// rtl/qam_rx_symbol_sampler_pkg.sv - shared constants for the 16-QAM receive symbol sampler
package qam_rx_pkg;

    // Baud-rate selector codes
    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_e;

    // Samples per symbol at 76800 Hz input rate
    localparam int OSR_2400  = 32;
    localparam int OSR_4800  = 16;
    localparam int OSR_9600  = 8;
    localparam int OSR_19200 = 4;

    localparam int PHASE_W = 5;

    // Gray-coded per-axis decision levels
    localparam logic [1:0] LVL_P3 = 2'b10;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_M3 = 2'b00;

    // Highest phase index (OSR-1) for a baud code; doubles as the phase mask
    function automatic logic [PHASE_W-1:0] osr_last(input logic [1:0] baud);
        case (baud)
            BAUD_2400:  osr_last = PHASE_W'(OSR_2400 - 1);
            BAUD_4800:  osr_last = PHASE_W'(OSR_4800 - 1);
            BAUD_9600:  osr_last = PHASE_W'(OSR_9600 - 1);
            default:    osr_last = PHASE_W'(OSR_19200 - 1);
        endcase
    endfunction

endpackage

// File: rtl/qam_rx_symbol_sampler_if.sv
// rtl/qam_rx_symbol_sampler_if.sv - sample input and symbol output handshake bundle
interface qam_rx_symbol_sampler_if #(
    parameter int IN_W = 65
);
    logic                   in_valid;
    logic signed [IN_W-1:0] in_i;
    logic signed [IN_W-1:0] in_q;
    logic                   sym_valid;
    logic                   sym_ready;
    logic [3:0]             sym_data;

    // Upstream filter / downstream demapper side
    modport master (
        output in_valid, in_i, in_q, sym_ready,
        input  sym_valid, sym_data
    );

    // Sampler side
    modport slave (
        input  in_valid, in_i, in_q, sym_ready,
        output sym_valid, sym_data
    );
endinterface

// File: rtl/qam_rx_symbol_sampler_fifo.sv
// rtl/qam_rx_symbol_sampler_fifo.sv - synchronous symbol FIFO with flush and registered head
module qam_rx_sym_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] remaining;
    logic [W-1:0]  head_nxt;
    logic          wr;
    logic          rd;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign rd         = pop & ~empty;
    assign wr         = push & (~full | rd);
    assign rd_ptr_nxt = rd ? rd_ptr + AW'(1) : rd_ptr;
    assign remaining  = count - CW'(rd);

    // Next head value: oldest surviving entry, or the incoming word when it lands in an empty queue
    always_comb begin
        head_nxt = dout;
        if (!flush) begin
            if (remaining != '0) begin
                head_nxt = mem[rd_ptr_nxt];
            end else if (wr) begin
                head_nxt = din;
            end
        end
    end

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            dout <= head_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                rd_ptr <= rd_ptr_nxt;
                case ({wr, rd})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: rtl/qam_rx_symbol_sampler.sv
// rtl/qam_rx_symbol_sampler.sv - symbol-rate decimator, 16-QAM slicer and output queue
module qam_rx_symbol_sampler
    import qam_rx_pkg::*;
#(
    parameter int IN_W       = 65,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          baud_rate,
    input  logic [PHASE_W-1:0]  sample_phase,
    input  logic [IN_W-1:0]     thr,
    input  logic                overflow_clr,
    output logic                overflow,
    output logic [CNT_W-1:0]    sym_count,
    qam_rx_symbol_sampler_if.slave bus
);
    logic [1:0]         baud_q;
    logic [PHASE_W-1:0] pc;
    logic [PHASE_W-1:0] osr_lim;
    logic [PHASE_W-1:0] ph;
    logic               baud_chg;
    logic               capture;
    logic               s1_valid;
    logic [3:0]         s1_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               wr_accept;
    logic               drop;

    // Four-level decision on one axis, done one bit wider so -thr never overflows
    function automatic logic [1:0] slice(input logic signed [IN_W-1:0] x,
                                         input logic [IN_W-1:0] t);
        logic signed [IN_W:0] xe;
        logic signed [IN_W:0] te;
        logic signed [IN_W:0] nte;
        xe  = {x[IN_W-1], x};
        te  = {1'b0, t};
        nte = -te;
        if (xe >= te) begin
            slice = LVL_P3;
        end else if (!xe[IN_W]) begin
            slice = LVL_P1;
        end else if (xe >= nte) begin
            slice = LVL_M1;
        end else begin
            slice = LVL_M3;
        end
    endfunction

    assign osr_lim   = osr_last(baud_rate);
    assign ph        = sample_phase & osr_lim;
    assign baud_chg  = (baud_rate != baud_q);
    assign capture   = enable & bus.in_valid & (pc == ph) & ~baud_chg;

    assign bus.sym_valid = ~fifo_empty;
    assign fifo_pop  = bus.sym_valid & bus.sym_ready;
    assign fifo_push = s1_valid & ~baud_chg;
    assign wr_accept = fifo_push & (~fifo_full | fifo_pop);
    assign drop      = fifo_push & fifo_full & ~fifo_pop;

    // Remember the last baud setting so a change can resynchronise the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_rate;
        end
    end

    // Phase counter over one symbol period; restarts on baud change or while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (baud_chg || !enable) begin
            pc <= '0;
        end else if (bus.in_valid) begin
            pc <= (pc == osr_lim) ? '0 : pc + PHASE_W'(1);
        end
    end

    // Stage 1: sliced symbol waiting one cycle before entering the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_bits  <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_bits <= {slice(bus.in_i, thr), slice(bus.in_q, thr)};
            end
        end
    end

    // Sticky drop flag; a new drop beats a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Running count of symbols accepted into the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count <= '0;
        end else if (wr_accept) begin
            sym_count <= sym_count + CNT_W'(1);
        end
    end

    qam_rx_sym_fifo #(
        .W     (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (baud_chg),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s1_bits),
        .dout  (bus.sym_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_qam_rx_symbol_sampler.sv
// tb/tb_qam_rx_symbol_sampler.sv - randomized self-checking bench for the QAM symbol sampler
module tb_qam_rx_symbol_sampler;
    localparam int IN_W  = 65;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [1:0]      baud_rate;
    logic [4:0]      sample_phase;
    logic [IN_W-1:0] thr;
    logic            overflow_clr;
    logic            overflow;
    logic [15:0]     sym_count;

    int vec  = 0;
    int errs = 0;

    qam_rx_symbol_sampler_if #(.IN_W(IN_W)) bus ();

    qam_rx_symbol_sampler #(.IN_W(IN_W), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .baud_rate    (baud_rate),
        .sample_phase (sample_phase),
        .thr          (thr),
        .overflow_clr (overflow_clr),
        .overflow     (overflow),
        .sym_count    (sym_count),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: sample index since resync, queued symbols, pending slice
    int         m_n;
    logic [3:0] m_q[$];
    bit         m_sv;
    logic [3:0] m_sb;
    logic [3:0] m_last;
    bit         m_ovf;
    logic [15:0] m_cnt;
    logic [1:0] m_baud;

    function automatic logic [1:0] lvl(input longint x, input longint t);
        if (x >= t)       return 2'b10;
        else if (x >= 0)  return 2'b11;
        else if (x >= -t) return 2'b01;
        else              return 2'b00;
    endfunction

    function automatic longint level_val(input logic [1:0] b);
        case (b)
            2'b10:   return 2000;
            2'b11:   return 500;
            2'b01:   return -500;
            default: return -2000;
        endcase
    endfunction

    function automatic longint rnd();
        return longint'($urandom_range(6000)) - 3000;
    endfunction

    task automatic model_reset();
        m_n = 0; m_q.delete(); m_sv = 0; m_sb = '0; m_last = '0;
        m_ovf = 0; m_cnt = '0; m_baud = 2'b00;
    endtask

    // One clock edge of the behaviour, from the current inputs
    task automatic model_edge();
        int osr;
        int ph;
        bit chg;
        bit pop;
        bit drop;
        osr  = 32 >> baud_rate;
        ph   = int'(sample_phase) % osr;
        chg  = (baud_rate != m_baud);
        pop  = (m_q.size() != 0) && bus.sym_ready;
        drop = 0;
        if (chg) begin
            m_q.delete(); m_sv = 0; m_n = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_sv) begin
                if (m_q.size() < DEPTH) begin m_q.push_back(m_sb); m_cnt++; end
                else drop = 1;
            end
            m_sv = enable && bus.in_valid && (m_n % osr == ph);
            m_sb = {lvl(longint'(bus.in_i), longint'(thr)), lvl(longint'(bus.in_q), longint'(thr))};
            if (!enable) m_n = 0;
            else if (bus.in_valid) m_n++;
        end
        if (drop) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        m_baud = baud_rate;
        if (m_q.size() != 0) m_last = m_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input longint i, input longint q);
        bus.in_valid = v;
        bus.in_i     = i;
        bus.in_q     = q;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        enable = 1'b1; baud_rate = 2'b00; sample_phase = '0; thr = IN_W'(1000);
        overflow_clr = 1'b0; bus.sym_ready = 1'b0;
        drive(0, 0, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vec++;
        if (bus.sym_valid !== 1'b0 || bus.sym_data !== 4'b0 || overflow !== 1'b0 || sym_count !== 16'd0) begin
            errs++;
            $display("FAIL reset valid=%b data=%b ovf=%b cnt=%0d required all zero",
                     bus.sym_valid, bus.sym_data, overflow, sym_count);
        end
    endtask

    task automatic test_phase_capture();
        apply_reset();
        baud_rate = 2'b11; sample_phase = 5'd2; thr = IN_W'(1000);
        drive(0, 0, 0); tick(); tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 2) drive(1, 1500, -200);
            else        drive(k < 4, rnd(), rnd());
            tick();
            vec++;
            if (bus.sym_valid !== (m_q.size() != 0) || bus.sym_data !== m_last || overflow !== m_ovf || sym_count !== m_cnt) begin
                errs++;
                $display("FAIL phase_model k=%0d valid=%b/%b data=%b/%b ovf=%b/%b cnt=%0d/%0d", k,
                         bus.sym_valid, m_q.size() != 0, bus.sym_data, m_last, overflow, m_ovf, sym_count, m_cnt);
            end
            if (k == 2) begin
                vec++;
                if (bus.sym_valid !== 1'b0) begin errs++; $display("FAIL phase_latency valid=%b required 0", bus.sym_valid); end
            end
            if (k == 3) begin
                vec++;
                if (bus.sym_valid !== 1'b1 || bus.sym_data !== 4'b1001 || sym_count !== 16'd1) begin
                    errs++;
                    $display("FAIL phase_symbol valid=%b data=%b cnt=%0d required 1 1001 1", bus.sym_valid, bus.sym_data, sym_count);
                end
            end
            if (k == 5) begin
                vec++;
                if (sym_count !== 16'd1) begin errs++; $display("FAIL phase_ignored cnt=%0d required 1", sym_count); end
            end
        end
    endtask

    task automatic test_baud00();
        int expc;
        apply_reset();
        baud_rate = 2'b00; sample_phase = 5'd31; bus.sym_ready = 1'b1;
        tick(); tick();
        for (int k = 0; k < 98; k++) begin
            drive(k < 96, rnd(), rnd());
            tick();
            expc = int'(k >= 32) + int'(k >= 64) + int'(k >= 96);
            vec++;
            if (sym_count !== 16'(expc) || bus.sym_data !== m_last || bus.sym_valid !== (m_q.size() != 0)) begin
                errs++;
                $display("FAIL baud00 k=%0d cnt=%0d/%0d data=%b/%b valid=%b", k, sym_count, expc, bus.sym_data, m_last, bus.sym_valid);
            end
        end
    endtask

    task automatic test_slicer_boundary();
        longint     iv[10] = '{1000, 999, 0, -1, -1000, -1001, 5, 0, -1, -7};
        longint     qv[10] = '{-1000, -999, 0, 1, 1000, 1001, -3, 1, 0, -1};
        logic [3:0] ev[10] = '{4'b1001, 4'b1101, 4'b1111, 4'b0111, 4'b0110, 4'b0010,
                               4'b1000, 4'b1010, 4'b0010, 4'b0000};
        int j = 0;
        apply_reset();
        baud_rate = 2'b11; sample_phase = 5'd0; bus.sym_ready = 1'b1;
        tick(); tick();
        for (int s = 0; s < 12; s++) begin
            for (int k = 0; k < 4; k++) begin
                thr = (s < 6) ? IN_W'(1000) : IN_W'(0);
                if (k == 0 && s < 10) drive(1, iv[s], qv[s]);
                else                  drive(s < 10, rnd(), rnd());
                tick();
                if (bus.sym_valid === 1'b1) begin
                    vec++;
                    if (j >= 10 || bus.sym_data !== ev[j]) begin
                        errs++;
                        $display("FAIL slicer idx=%0d data=%b required %b", j, bus.sym_data, (j < 10) ? ev[j] : 4'bx);
                    end
                    j++;
                end
            end
        end
        vec++;
        if (j != 10) begin errs++; $display("FAIL slicer_count got=%0d required 10", j); end
    endtask

    task automatic fill_codes(input logic [3:0] c[6], input int nsym, input int ready_at);
        int n = 0;
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < 4; k++) begin
                bus.sym_ready = (n == ready_at);
                if (k == 0) drive(1, level_val(c[s][3:2]), level_val(c[s][1:0]));
                else        drive(1, rnd(), rnd());
                tick();
                n++;
            end
        end
        bus.sym_ready = 1'b0;
        drive(0, 0, 0);
        tick(); tick();
    endtask

    task automatic test_overflow();
        logic [3:0] c[6] = '{4'b1001, 4'b0110, 4'b1100, 4'b0011, 4'b1111, 4'b0000};
        int j = 0;
        apply_reset();
        baud_rate = 2'b11; sample_phase = 5'd0;
        tick(); tick();
        fill_codes(c, 6, -1);
        vec++;
        if (overflow !== 1'b1 || sym_count !== 16'd4 || bus.sym_valid !== 1'b1) begin
            errs++;
            $display("FAIL overflow_set ovf=%b cnt=%0d valid=%b required 1 4 1", overflow, sym_count, bus.sym_valid);
        end
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        vec++;
        if (overflow !== 1'b0 || m_ovf !== 1'b0) begin errs++; $display("FAIL overflow_clr ovf=%b required 0", overflow); end
        bus.sym_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            if (bus.sym_valid === 1'b1) begin
                vec++;
                if (j >= 4 || bus.sym_data !== c[j]) begin
                    errs++;
                    $display("FAIL overflow_drain idx=%0d data=%b required %b", j, bus.sym_data, (j < 4) ? c[j] : 4'bx);
                end
                j++;
            end
            tick();
        end
        bus.sym_ready = 1'b0;
        vec++;
        if (j != 4 || overflow !== 1'b0) begin errs++; $display("FAIL overflow_drain_count got=%0d ovf=%b required 4 0", j, overflow); end
    endtask

    task automatic test_full_simul();
        logic [3:0] c[6] = '{4'b1110, 4'b0101, 4'b1011, 4'b0100, 4'b1000, 4'b0001};
        int j = 0;
        apply_reset();
        baud_rate = 2'b11; sample_phase = 5'd0;
        tick(); tick();
        fill_codes(c, 5, 17);
        vec++;
        if (overflow !== 1'b0 || sym_count !== 16'd5 || bus.sym_data !== c[1]) begin
            errs++;
            $display("FAIL full_simul ovf=%b cnt=%0d head=%b required 0 5 %b", overflow, sym_count, bus.sym_data, c[1]);
        end
        bus.sym_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (bus.sym_valid === 1'b1) begin
                vec++;
                if (j >= 4 || bus.sym_data !== c[j+1]) begin
                    errs++;
                    $display("FAIL full_drain idx=%0d data=%b required %b", j, bus.sym_data, (j < 4) ? c[j+1] : 4'bx);
                end
                j++;
            end
            tick();
        end
        bus.sym_ready = 1'b0;
        vec++;
        if (j != 4) begin errs++; $display("FAIL full_occupancy got=%0d required 4", j); end
    endtask

    task automatic test_baud_switch();
        apply_reset();
        baud_rate = 2'b11; sample_phase = 5'd5;
        tick(); tick();
        for (int k = 0; k < 10; k++) begin drive(k < 8, rnd(), rnd()); tick(); end
        vec++;
        if (bus.sym_valid !== 1'b1 || sym_count !== 16'd2) begin
            errs++; $display("FAIL switch_prefill valid=%b cnt=%0d required 1 2", bus.sym_valid, sym_count);
        end
        baud_rate = 2'b10; drive(0, 0, 0); tick();
        vec++;
        if (bus.sym_valid !== 1'b0 || sym_count !== 16'd2) begin
            errs++; $display("FAIL switch_flush valid=%b cnt=%0d required 0 2", bus.sym_valid, sym_count);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 5) drive(1, 2000, 2000);
            else        drive(1, rnd(), rnd());
            tick();
            vec++;
            if (bus.sym_valid !== (k >= 6) || bus.sym_data !== m_last || sym_count !== m_cnt) begin
                errs++;
                $display("FAIL switch_resync k=%0d valid=%b/%b data=%b/%b cnt=%0d/%0d", k,
                         bus.sym_valid, k >= 6, bus.sym_data, m_last, sym_count, m_cnt);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (bus.sym_valid !== 1'b0 || bus.sym_data !== 4'b0 || overflow !== 1'b0 || sym_count !== 16'd0) begin
            errs++;
            $display("FAIL async_reset valid=%b data=%b ovf=%b cnt=%0d required all zero",
                     bus.sym_valid, bus.sym_data, overflow, sym_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0); tick();
            vec++;
            if (bus.sym_valid !== 1'b0 || sym_count !== 16'd0) begin
                errs++; $display("FAIL post_reset k=%0d valid=%b cnt=%0d required 0 0", k, bus.sym_valid, sym_count);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 160 == 0) begin
                baud_rate    = 2'($urandom_range(3));
                sample_phase = 5'($urandom_range(31));
                thr          = IN_W'($urandom_range(2000));
            end
            enable        = ($urandom_range(15) != 0);
            bus.sym_ready = ($urandom_range(2) == 0);
            overflow_clr  = ($urandom_range(19) == 0);
            drive($urandom_range(3) != 0, rnd(), rnd());
            tick();
            vec++;
            if (bus.sym_valid !== (m_q.size() != 0) || bus.sym_data !== m_last || overflow !== m_ovf || sym_count !== m_cnt) begin
                errs++;
                $display("FAIL random n=%0d valid=%b/%b data=%b/%b ovf=%b/%b cnt=%0d/%0d", n,
                         bus.sym_valid, m_q.size() != 0, bus.sym_data, m_last, overflow, m_ovf, sym_count, m_cnt);
            end
        end
        enable = 1'b1; overflow_clr = 1'b0; bus.sym_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_phase_capture();
        test_baud00();
        test_slicer_boundary();
        test_overflow();
        test_full_simul();
        test_baud_switch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/qam_rx_symbol_sampler.md
Name: qam_rx_symbol_sampler

Overview:
Receive-side counterpart of the transmit pulse-shaping filter bank. It takes matched-filtered baseband I/Q samples at 76800 Hz. It decimates them to one strobe per symbol at a programmable sampling phase, according to the selected baud rate. Each strobed sample is sliced into a Gray-coded 16-QAM symbol. Symbols go through a small FIFO to the demapper/deframer over a valid/ready handshake.

Parameters:
IN_W, 65, width of signed I/Q input samples (matches matched-filter output width)
FIFO_DEPTH, 4, symbol FIFO entries; power of two, >= 2
CNT_W, 16, width of the free-running symbol counter

Ports:
clk  in  1  sample clock, 76800 Hz nominal
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  high: sampler runs; low: phase counter held at 0, no captures
baud_rate  in  2  00=2400, 01=4800, 10=9600, 11=19200 Bd
sample_phase  in  5  symbol sampling phase, masked to OSR-1
thr  in  IN_W  unsigned outer-level decision threshold (2A)
in_valid  in  1  I/Q sample valid this cycle
in_i  in  IN_W  signed I sample
in_q  in  IN_W  signed Q sample
sym_valid  out  1  FIFO head valid
sym_ready  in  1  consumer accepts head
sym_data  out  4  {i_bits[1:0], q_bits[1:0]}
overflow  out  1  sticky: a symbol was dropped
overflow_clr  in  1  clears overflow
sym_count  out  CNT_W  symbols written to FIFO, wraps

Behaviour:
- Reset values: sym_valid=0, sym_data=0, overflow=0, sym_count=0, phase counter=0, FIFO empty, pipeline stage empty.
- OSR = 32/16/8/4 for baud_rate 00/01/10/11. Effective phase ph = sample_phase & (OSR-1).
- Phase counter pc advances on each in_valid while enable=1: pc wraps from OSR-1 to 0.
- Capture condition: enable & in_valid & (pc == ph).
- baud_rate change is detected against a registered copy. In the cycle after the change: pc cleared, FIFO flushed, stage-1 register invalidated. A capture coinciding with the change cycle is discarded. overflow and sym_count are unaffected.
- enable low: pc held at 0 and no captures. The FIFO keeps draining normally.
- Slicer, per axis, signed x against thr:
  - x >= thr -> 2'b10 (+3)
  - 0 <= x < thr -> 2'b11 (+1)
  - -thr <= x < 0 -> 2'b01 (-1)
  - x < -thr -> 2'b00 (-3)
  - Comparisons use sign-extended IN_W+1 arithmetic. thr=0 gives the 2-level (QPSK) decision on the MSB of each axis.
- Pipeline: capture at edge E loads stage-1 {bits, valid}. The FIFO write occurs at edge E+1. With the FIFO empty, sym_valid goes high after edge E+1, i.e. 2-cycle latency.
- FIFO write accept = stage1_valid & (!full | (sym_valid & sym_ready)). Simultaneous read and write when full is legal and keeps it full.
- Full without a read: the symbol is dropped, overflow set, sym_count not incremented.
- If overflow_clr and a new drop coincide, the set wins.
- sym_count increments once per accepted FIFO write.
- The handshake transfers on sym_valid & sym_ready. sym_data is stable while sym_valid=1 and sym_ready=0. sym_ready while empty has no effect.
- sym_data shows the FIFO head, registered. It holds its last value when empty.
- Async reset mid-operation returns all state to reset values immediately. No partial symbol emerges after release.

Decomposition:
- Shared package qam_rx_pkg:
  - OSR lookup constants per baud_rate code.
  - Gray level encodings (LVL_P3=2'b10, LVL_P1=2'b11, LVL_M1=2'b01, LVL_M3=2'b00).
  - Baud code constants.
- One sub-module: qam_rx_sym_fifo, a synchronous FIFO.
  - Parameterised width/depth.
  - Outputs full/empty, supports simultaneous push/pop.
  - Has a flush input.

Test Plan:
- baud=11, ph=2, thr=1000, in_valid=1 continuously, sample index 2 I=+1500, Q=-200 -> sym_data=4'b1001 two cycles later, sym_count=1; indices 0,1,3 ignored.
- baud=00, ph=31, sym_ready=1, 96 continuous samples -> exactly 3 symbols, captured at samples 31, 63, 95.
- Boundary slicing with thr=1000, I in {1000, 999, 0, -1, -1000, -1001} -> i_bits {10, 11, 11, 01, 01, 00}.
- sym_ready=0, baud=11, produce 6 symbols, FIFO_DEPTH=4 -> 4 held, overflow=1, sym_count=4. Then pulse overflow_clr and drain -> the first 4 symbols come out in order and overflow=0.
- Full FIFO with sym_ready=1 during a write cycle -> both transfer, occupancy stays 4, no overflow.
- baud_rate switched 11->10 with 2 symbols queued -> FIFO flushed, sym_valid=0. The next symbol arrives at pc==ph under OSR=8. Assert rst_n mid-stream -> all outputs 0 immediately.
